branch_resolution_unit: RTL and testbench
=========================================

BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of the branch target and redirect PC.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of front-end flush cycles after a taken branch (legal range 1-15).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port br_valid, input, 1, decode presents a branch.
REQ-006 SHALL have port br_ready, output, 1, unit can accept a branch.
REQ-007 SHALL have port br_opcode, input, 3, branch opcode.
REQ-008 SHALL have port br_v, input, 1, unconditional-mode bit.
REQ-009 SHALL have port br_target, input, PC_WIDTH, branch target address.
REQ-010 SHALL have port flags_valid, input, 1, execute writes new flags this cycle.
REQ-011 SHALL have port flags_in, input, 4, {N,Z,C,V} from execute.
REQ-012 SHALL have port flags_pending, input, 1, an older flag-setting instruction is still in flight.
REQ-013 SHALL have port stall, output, 1, hold fetch/decode.
REQ-014 SHALL have port redirect_valid, output, 1, one-cycle redirect pulse.
REQ-015 SHALL have port redirect_pc, output, PC_WIDTH, redirect address.
REQ-016 SHALL have port flush, output, 1, kill fetch/decode contents.
REQ-017 SHALL have ports taken_cnt and not_taken_cnt, outputs, 16 each, resolved-branch statistics.

Function
REQ-018 SHALL keep a 4-bit flag register, written with flags_in on every cycle flags_valid=1, in any FSM state.
REQ-019 SHALL define effective flags as flags_in when flags_valid=1, else the flag register (same-cycle bypass).
REQ-020 SHALL accept a branch when br_valid & br_ready, capturing opcode, v and target.
REQ-021 SHALL implement FSM states IDLE, WAIT_FLAGS, RESOLVE and FLUSH; br_ready=1 only in IDLE; stall=1 in every state except IDLE.
REQ-022 IDLE: on accept with br_v=1 or flags_pending=0, the FSM SHALL go to RESOLVE, latching the effective flags; on accept otherwise it SHALL go to WAIT_FLAGS.
REQ-023 WAIT_FLAGS: when flags_pending=0, the FSM SHALL latch the effective flags and go to RESOLVE; otherwise it SHALL remain in WAIT_FLAGS (no timeout).
REQ-024 RESOLVE SHALL last exactly one cycle, evaluating the condition on the latched flags.
REQ-025 Condition with v=1: opcode 111 SHALL be taken; all other opcodes SHALL be not taken.
REQ-026 Condition with v=0: 111 SHALL be taken on Z; 100 on ~Z; 101 on ~Z & ~(N^V); 110 on N^V; all other opcodes SHALL be not taken.
REQ-027 A taken branch in RESOLVE SHALL pulse redirect_valid=1 with redirect_pc=target, increment taken_cnt, and move the FSM to FLUSH.
REQ-028 A not-taken branch in RESOLVE SHALL increment not_taken_cnt and return the FSM to IDLE; redirect_valid SHALL stay 0.
REQ-029 FLUSH SHALL assert flush=1 for exactly FLUSH_CYCLES consecutive cycles using a down-counter, then return to IDLE.
REQ-030 Latency with no pending flags: accept at cycle 0, resolve/redirect at cycle 1; not taken gives br_ready=1 at cycle 2; taken gives br_ready=1 at cycle 2+FLUSH_CYCLES.
REQ-031 redirect_pc SHALL be 0 whenever redirect_valid=0.
REQ-032 Counters SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-033 rst_n=0 SHALL immediately, from any state including mid-wait or mid-flush, force IDLE, the flag register to 0, both counters to 0, the flush counter to 0, and outputs to br_ready=1, stall=0, redirect_valid=0, redirect_pc=0 and flush=0.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the opcode constants (OP_B_EQ=111, OP_NE=100, OP_GT=101, OP_LT=110) and the flag bit indices.
REQ-035 Condition evaluation SHALL instantiate the existing condition_checker as the single sub-module; the FSM, flag register and counters SHALL be local.

Verification
REQ-036 V=1 branch, opcode 111, target 0x100, FLUSH_CYCLES=2 -> redirect_valid and redirect_pc=0x100 at cycle 1, flush at cycles 2-3, br_ready at cycle 4, taken_cnt=1.
REQ-037 V=0 opcode 111 while flags_pending=1; flags_valid with Z=1 at cycle 3 and flags_pending drops at cycle 3 -> RESOLVE at cycle 4, redirect at cycle 4.
REQ-038 V=0 opcode 101 with effective N=1, V=0, Z=0 -> not taken, no redirect, br_ready at cycle 2, not_taken_cnt=1.
REQ-039 Same-cycle bypass: accept LT with flags_valid=1 and flags_in N=1, V=0 while the flag register holds 0 -> taken.
REQ-040 rst_n asserted during FLUSH cycle 1 -> flush=0 and br_ready=1 immediately; after release, a new branch is accepted normally.
REQ-041 Counter wrap: preload 0xFFFF taken branches, then 1 more -> taken_cnt=0x0000.

Source files
------------

// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and constants for the branch resolution unit: FSM states,
// branch opcodes and flag bit positions within the {N,Z,C,V} flag nibble.
package branch_resolution_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFlags,
    StResolve,
    StFlush
  } bru_state_e;

  localparam logic [2:0] OP_B_EQ = 3'b111;
  localparam logic [2:0] OP_NE   = 3'b100;
  localparam logic [2:0] OP_GT   = 3'b101;
  localparam logic [2:0] OP_LT   = 3'b110;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/condition_checker.sv
// Purely combinational branch condition evaluation on a {N,Z,C,V} flag set.
// With v_i=1 only OP_B_EQ is taken (unconditional branch form).
module condition_checker
  import branch_resolution_unit_pkg::*;
(
  input  logic [2:0] opcode_i,
  input  logic       v_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic flag_n, flag_z, flag_v;
  logic unused_flag_c;

  assign flag_n        = flags_i[FLAG_N];
  assign flag_z        = flags_i[FLAG_Z];
  assign flag_v        = flags_i[FLAG_V];
  assign unused_flag_c = flags_i[FLAG_C];

  always_comb begin
    taken_o = 1'b0;
    if (v_i) begin
      taken_o = (opcode_i == OP_B_EQ);
    end else begin
      unique case (opcode_i)
        OP_B_EQ: taken_o = flag_z;
        OP_NE:   taken_o = ~flag_z;
        OP_GT:   taken_o = ~flag_z & ~(flag_n ^ flag_v);
        OP_LT:   taken_o = flag_n ^ flag_v;
        default: taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution: waits for flags if needed, resolves the branch, issues a
// one-cycle redirect and a fixed-length front-end flush on taken branches.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                br_valid,
  output logic                br_ready,
  input  logic [2:0]          br_opcode,
  input  logic                br_v,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                flags_valid,
  input  logic [3:0]          flags_in,
  input  logic                flags_pending,
  output logic                stall,
  output logic                redirect_valid,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic [15:0]         taken_cnt,
  output logic [15:0]         not_taken_cnt
);

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  bru_state_e          state_q, state_d;
  logic [3:0]          flags_q, flags_d;
  logic [3:0]          lflags_q, lflags_d;
  logic [2:0]          op_q, op_d;
  logic                v_q, v_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [15:0]         taken_cnt_q, taken_cnt_d;
  logic [15:0]         not_taken_cnt_q, not_taken_cnt_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;

  logic [3:0] eff_flags;
  logic       cond_taken;

  // Same-cycle bypass: flags written this cycle are already visible.
  assign eff_flags = flags_valid ? flags_in : flags_q;
  assign flags_d   = eff_flags;

  condition_checker u_condition_checker (
    .opcode_i (op_q),
    .v_i      (v_q),
    .flags_i  (lflags_q),
    .taken_o  (cond_taken)
  );

  always_comb begin
    state_d         = state_q;
    lflags_d        = lflags_q;
    op_d            = op_q;
    v_d             = v_q;
    target_d        = target_q;
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    br_ready        = 1'b0;
    stall           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    flush           = 1'b0;

    unique case (state_q)
      StIdle: begin
        br_ready = 1'b1;
        stall    = 1'b0;
        if (br_valid) begin
          op_d     = br_opcode;
          v_d      = br_v;
          target_d = br_target;
          if (br_v || !flags_pending) begin
            lflags_d = eff_flags;
            state_d  = StResolve;
          end else begin
            state_d = StWaitFlags;
          end
        end
      end
      StWaitFlags: begin
        if (!flags_pending) begin
          lflags_d = eff_flags;
          state_d  = StResolve;
        end
      end
      StResolve: begin
        if (cond_taken) begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          taken_cnt_d    = taken_cnt_q + 16'd1;
          flush_cnt_d    = FlushLoad;
          state_d        = StFlush;
        end else begin
          not_taken_cnt_d = not_taken_cnt_q + 16'd1;
          state_d         = StIdle;
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (flush_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      flags_q         <= '0;
      lflags_q        <= '0;
      op_q            <= '0;
      v_q             <= 1'b0;
      target_q        <= '0;
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      flags_q         <= flags_d;
      lflags_q        <= lflags_d;
      op_q            <= op_d;
      v_q             <= v_d;
      target_q        <= target_d;
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed self-checking bench for branch_resolution_unit (FLUSH_CYCLES=2).
module tb_branch_resolution_unit;

  localparam int unsigned PW = 32;
  localparam int unsigned FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          br_valid;
  logic          br_ready;
  logic [2:0]    br_opcode;
  logic          br_v;
  logic [PW-1:0] br_target;
  logic          flags_valid;
  logic [3:0]    flags_in;
  logic          flags_pending;
  logic          stall;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          flush;
  logic [15:0]   taken_cnt;
  logic [15:0]   not_taken_cnt;

  int errors = 0;
  int checks = 0;
  int exp_tk = 0;
  int exp_nt = 0;

  branch_resolution_unit #(
    .PC_WIDTH     (PW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_opcode      (br_opcode),
    .br_v           (br_v),
    .br_target      (br_target),
    .flags_valid    (flags_valid),
    .flags_in       (flags_in),
    .flags_pending  (flags_pending),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .taken_cnt      (taken_cnt),
    .not_taken_cnt  (not_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid      = 1'b0;
    br_opcode     = 3'b000;
    br_v          = 1'b0;
    br_target     = '0;
    flags_valid   = 1'b0;
    flags_in      = 4'b0000;
    flags_pending = 1'b0;
  endtask

  // Entered with the FSM idle; accepts one branch with no pending flags and
  // runs it to completion. use_fv selects bypassed flags vs. the flag register.
  task automatic run_branch(input logic [2:0] op, input logic v, input logic [3:0] fl,
                            input logic use_fv, input logic want, input logic [PW-1:0] tgt);
    br_valid    = 1'b1;
    br_opcode   = op;
    br_v        = v;
    br_target   = tgt;
    flags_valid = use_fv;
    flags_in    = fl;
    #1;
    checks++;
    if (br_ready !== 1'b1) begin errors++; $error("FAIL accept_ready"); end
    step();
    idle_inputs();
    #1;
    checks++;
    if (redirect_valid !== want) begin
      errors++; $error("FAIL redirect_valid: %0h want %0h", redirect_valid, want);
    end
    checks++;
    if (redirect_pc !== (want ? tgt : 32'h0)) begin
      errors++; $error("FAIL redirect_pc: %0h", redirect_pc);
    end
    if (want) exp_tk++;
    else exp_nt++;
    if (want) begin
      step();
      checks++;
      if (flush !== 1'b1) begin errors++; $error("FAIL flush_c1"); end
      step();
      checks++;
      if (flush !== 1'b1) begin errors++; $error("FAIL flush_c2"); end
    end
    step();
    checks++;
    if (br_ready !== 1'b1) begin errors++; $error("FAIL ready_after"); end
    checks++;
    if (flush !== 1'b0) begin errors++; $error("FAIL flush_after"); end
    checks++;
    if (taken_cnt !== 16'(exp_tk)) begin
      errors++; $error("FAIL taken_cnt: %0h want %0h", taken_cnt, 16'(exp_tk));
    end
    checks++;
    if (not_taken_cnt !== 16'(exp_nt)) begin
      errors++; $error("FAIL not_taken_cnt: %0h want %0h", not_taken_cnt, 16'(exp_nt));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    checks++;
    if (br_ready !== 1'b1) begin errors++; $error("FAIL rst_ready"); end
    checks++;
    if (stall !== 1'b0) begin errors++; $error("FAIL rst_stall"); end
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $error("FAIL rst_redirect"); end
    checks++;
    if (redirect_pc !== 32'h0) begin errors++; $error("FAIL rst_redirect_pc"); end
    checks++;
    if (flush !== 1'b0) begin errors++; $error("FAIL rst_flush"); end
    checks++;
    if (taken_cnt !== 16'h0) begin errors++; $error("FAIL rst_taken"); end
    checks++;
    if (not_taken_cnt !== 16'h0) begin errors++; $error("FAIL rst_not_taken"); end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Bypass: flag register is 0, LT sees N=1,V=0 from flags_in -> taken.
    run_branch(3'b110, 1'b0, 4'b1000, 1'b1, 1'b1, 32'h0000_0ABC);

    // Unconditional branch while flags are pending: no wait for flags.
    br_valid      = 1'b1;
    br_opcode     = 3'b111;
    br_v          = 1'b1;
    br_target     = 32'h0000_0100;
    flags_pending = 1'b1;
    #1;
    checks++;
    if (br_ready !== 1'b1) begin errors++; $error("FAIL b_c0_ready"); end
    step();
    idle_inputs();
    #1;
    checks++;
    if (redirect_valid !== 1'b1) begin errors++; $error("FAIL b_c1_redirect"); end
    checks++;
    if (redirect_pc !== 32'h0000_0100) begin errors++; $error("FAIL b_c1_pc"); end
    checks++;
    if (stall !== 1'b1) begin errors++; $error("FAIL b_c1_stall"); end
    checks++;
    if (br_ready !== 1'b0) begin errors++; $error("FAIL b_c1_ready"); end
    exp_tk++;
    step();
    checks++;
    if (flush !== 1'b1) begin errors++; $error("FAIL b_c2_flush"); end
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $error("FAIL b_c2_redirect"); end
    checks++;
    if (redirect_pc !== 32'h0) begin errors++; $error("FAIL b_c2_pc"); end
    step();
    checks++;
    if (flush !== 1'b1) begin errors++; $error("FAIL b_c3_flush"); end
    checks++;
    if (br_ready !== 1'b0) begin errors++; $error("FAIL b_c3_ready"); end
    step();
    checks++;
    if (flush !== 1'b0) begin errors++; $error("FAIL b_c4_flush"); end
    checks++;
    if (br_ready !== 1'b1) begin errors++; $error("FAIL b_c4_ready"); end
    checks++;
    if (taken_cnt !== 16'(exp_tk)) begin errors++; $error("FAIL b_c4_taken"); end

    // GT with N=1,V=0,Z=0 -> not taken, ready again at cycle 2.
    run_branch(3'b101, 1'b0, 4'b1000, 1'b1, 1'b0, 32'h0000_0400);

    // Conditional BEQ waits for flags; Z=1 arrives as pending drops at cycle 3.
    br_valid      = 1'b1;
    br_opcode     = 3'b111;
    br_v          = 1'b0;
    br_target     = 32'h0000_0200;
    flags_pending = 1'b1;
    step();
    br_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $error("FAIL w_c1_redirect"); end
    checks++;
    if (stall !== 1'b1) begin errors++; $error("FAIL w_c1_stall"); end
    checks++;
    if (br_ready !== 1'b0) begin errors++; $error("FAIL w_c1_ready"); end
    step();
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $error("FAIL w_c2_redirect"); end
    step();
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $error("FAIL w_c3_redirect"); end
    checks++;
    if (stall !== 1'b1) begin errors++; $error("FAIL w_c3_stall"); end
    flags_valid   = 1'b1;
    flags_in      = 4'b0100;
    flags_pending = 1'b0;
    step();
    idle_inputs();
    #1;
    checks++;
    if (redirect_valid !== 1'b1) begin errors++; $error("FAIL w_c4_redirect"); end
    checks++;
    if (redirect_pc !== 32'h0000_0200) begin errors++; $error("FAIL w_c4_pc"); end
    exp_tk++;
    step();
    checks++;
    if (flush !== 1'b1) begin errors++; $error("FAIL w_c5_flush"); end
    step();
    checks++;
    if (flush !== 1'b1) begin errors++; $error("FAIL w_c6_flush"); end
    step();
    checks++;
    if (br_ready !== 1'b1) begin errors++; $error("FAIL w_c7_ready"); end
    checks++;
    if (taken_cnt !== 16'(exp_tk)) begin errors++; $error("FAIL w_c7_taken"); end

    // Condition table, all via bypassed flags {N,Z,C,V}.
    run_branch(3'b111, 1'b1, 4'b0000, 1'b1, 1'b1, 32'h0000_1000);
    run_branch(3'b100, 1'b1, 4'b0000, 1'b1, 1'b0, 32'h0000_1004);
    run_branch(3'b111, 1'b0, 4'b0100, 1'b1, 1'b1, 32'h0000_1008);
    run_branch(3'b111, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0000_100C);
    run_branch(3'b100, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0000_1010);
    run_branch(3'b100, 1'b0, 4'b0100, 1'b1, 1'b0, 32'h0000_1014);
    run_branch(3'b101, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0000_1018);
    run_branch(3'b101, 1'b0, 4'b1001, 1'b1, 1'b1, 32'h0000_101C);
    run_branch(3'b101, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0000_1020);
    run_branch(3'b101, 1'b0, 4'b1100, 1'b1, 1'b0, 32'h0000_1024);
    run_branch(3'b110, 1'b0, 4'b0001, 1'b1, 1'b1, 32'h0000_1028);
    run_branch(3'b110, 1'b0, 4'b1001, 1'b1, 1'b0, 32'h0000_102C);
    run_branch(3'b011, 1'b0, 4'b1111, 1'b1, 1'b0, 32'h0000_1030);
    run_branch(3'b000, 1'b1, 4'b1111, 1'b1, 1'b0, 32'h0000_1034);

    // Flag register write while idle, then use it without bypass: Z=1 -> BEQ taken.
    flags_valid = 1'b1;
    flags_in    = 4'b0100;
    step();
    idle_inputs();
    run_branch(3'b111, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0000_2000);

    // Reset during the first flush cycle.
    br_valid  = 1'b1;
    br_opcode = 3'b111;
    br_v      = 1'b1;
    br_target = 32'h0000_0300;
    step();
    idle_inputs();
    step();
    checks++;
    if (flush !== 1'b1) begin errors++; $error("FAIL r_flush_before"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0) begin errors++; $error("FAIL r_flush"); end
    checks++;
    if (br_ready !== 1'b1) begin errors++; $error("FAIL r_ready"); end
    checks++;
    if (stall !== 1'b0) begin errors++; $error("FAIL r_stall"); end
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $error("FAIL r_redirect"); end
    checks++;
    if (taken_cnt !== 16'h0) begin errors++; $error("FAIL r_taken"); end
    checks++;
    if (not_taken_cnt !== 16'h0) begin errors++; $error("FAIL r_not_taken"); end
    exp_tk = 0;
    exp_nt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Flag register cleared by reset: BEQ on register flags is not taken.
    run_branch(3'b111, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0000_3000);
    run_branch(3'b111, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000_3004);

    // Counter wrap: preset taken count to 0xFFFF, one more taken branch wraps to 0.
    force dut.taken_cnt_q = 16'hFFFF;
    #1;
    release dut.taken_cnt_q;
    #1;
    exp_tk = 32'hFFFF;
    run_branch(3'b111, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000_4000);
    checks++;
    if (taken_cnt !== 16'h0000) begin errors++; $error("FAIL wrap_taken: %0h", taken_cnt); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
